mem_arbiter: RTL and testbench

Round-robin arbiter that shares one downstream memory/peripheral port between the four CPU memory requesters: imem0, imem1, dmem0 and dmem1. It sits between the per-port address decode and the peripheral address decoder. It captures single-cycle requests into per-port buffers and serialises them with one outstanding transaction. Each response is routed back to the originating port, and a response timeout guarantees forward progress.

---
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one downstream memory port between four CPU requesters.
// Requests are buffered per port and serialised with a single outstanding transaction.
package mem_arbiter_pkg;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = DATA_W / 8;

  typedef struct packed {
    logic              mem_valid;
    logic              mem_instr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
  } mem_in_type;

  typedef struct packed {
    logic              mem_ready;
    logic              mem_error;
    logic [DATA_W-1:0] mem_rdata;
  } mem_out_type;

  localparam mem_in_type  init_mem_in  = '0;
  localparam mem_out_type init_mem_out = '0;
endpackage

module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned timeout = 1024
) (
  input  logic        reset,
  input  logic        clock,
  input  mem_in_type  req0_in,
  input  mem_in_type  req1_in,
  input  mem_in_type  req2_in,
  input  mem_in_type  req3_in,
  output mem_out_type req0_out,
  output mem_out_type req1_out,
  output mem_out_type req2_out,
  output mem_out_type req3_out,
  output mem_in_type  mem_in,
  input  mem_out_type mem_out
);
  localparam int unsigned NUM_PORTS = 4;
  localparam int unsigned CNT_W     = $clog2(timeout) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(timeout - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t           state;
  state_t           state_nxt;
  mem_in_type       req_in  [NUM_PORTS];
  mem_out_type      req_out [NUM_PORTS];
  mem_in_type       req_buf [NUM_PORTS];
  logic [3:0]       pend;
  logic [1:0]       sel;
  logic [1:0]       last;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             pick_valid;
  logic [CNT_W-1:0] cnt;
  logic             done;
  mem_out_type      done_rsp;

  assign req_in[0] = req0_in;
  assign req_in[1] = req1_in;
  assign req_in[2] = req2_in;
  assign req_in[3] = req3_in;
  assign req0_out  = req_out[0];
  assign req1_out  = req_out[1];
  assign req2_out  = req_out[2];
  assign req3_out  = req_out[3];

  // Lowest index after the last served port wins; last itself is scanned last.
  always_comb begin
    pick       = last;
    pick_valid = 1'b0;
    idx        = '0;
    for (int i = NUM_PORTS; i >= 1; i--) begin
      idx = last + 2'(i);
      if (pend[idx]) begin
        pick       = idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state, downstream request and completion routing.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    done_rsp  = init_mem_out;
    mem_in    = init_mem_in;
    for (int p = 0; p < NUM_PORTS; p++) req_out[p] = init_mem_out;
    case (state)
      IDLE: begin
        if (pick_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        mem_in           = req_buf[sel];
        mem_in.mem_valid = 1'b1;
        state_nxt        = WAIT;
      end
      WAIT: begin
        mem_in           = req_buf[sel];
        mem_in.mem_valid = 1'b0;
        if (mem_out.mem_ready) begin
          done     = 1'b1;
          done_rsp = mem_out;
        end else if (cnt == CNT_LAST) begin
          done               = 1'b1;
          done_rsp.mem_ready = 1'b1;
          done_rsp.mem_error = 1'b1;
        end
        if (done) begin
          req_out[sel] = done_rsp;
          state_nxt    = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture buffers: a valid on the completing port refills its buffer in the same cycle.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend <= '0;
      for (int p = 0; p < NUM_PORTS; p++) req_buf[p] <= init_mem_in;
      last <= 2'd3;
      sel  <= 2'd0;
      cnt  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (req_in[p].mem_valid && (!pend[p] || (done && sel == 2'(p)))) begin
          req_buf[p] <= req_in[p];
          pend[p]    <= 1'b1;
        end else if (done && sel == 2'(p)) begin
          pend[p] <= 1'b0;
        end
      end
      if (state == IDLE && pick_valid) sel <= pick;
      if (done) last <= sel;
      if (state == ISSUE)                     cnt <= '0;
      else if (state == WAIT && cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table-driven arbitration rows plus hand sequences,
// with issue/response scoreboards and a simple downstream responder.
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int unsigned TMO = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  mem_in_type  req_in  [4];
  mem_out_type req_out [4];
  mem_in_type  mem_in;
  mem_out_type mem_out;

  always #5 clock = ~clock;

  mem_arbiter #(.timeout(TMO)) dut (
    .reset   (reset),
    .clock   (clock),
    .req0_in (req_in[0]),
    .req1_in (req_in[1]),
    .req2_in (req_in[2]),
    .req3_in (req_in[3]),
    .req0_out(req_out[0]),
    .req1_out(req_out[1]),
    .req2_out(req_out[2]),
    .req3_out(req_out[3]),
    .mem_in  (mem_in),
    .mem_out (mem_out)
  );

  typedef struct { mem_in_type req; int cyc; } iss_t;
  typedef struct { int port; mem_out_type rsp; int cyc; } rsp_t;
  typedef struct {
    string       name;
    logic [3:0]  mask;
    int          lat;
    logic [31:0] base;
    logic [31:0] seed;
  } row_t;

  iss_t        iss_q[$];
  rsp_t        rsp_q[$];
  logic [31:0] rdata_q[$];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          resp_lat = 1;
  int          resp_due = -1;
  logic [31:0] resp_word = '0;
  logic        force_ready = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Downstream model: answers resp_lat cycles after each issue, or stays silent when 0.
  always @(negedge clock) begin
    if (mem_in.mem_valid === 1'b1 && resp_lat > 0) begin
      resp_due  = cyc + resp_lat;
      resp_word = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'h0;
    end
  end

  always @(posedge clock) begin
    #2;
    mem_out = '0;
    if (cyc == resp_due) begin
      mem_out.mem_ready = 1'b1;
      mem_out.mem_rdata = resp_word;
    end else if (force_ready) begin
      mem_out.mem_ready = 1'b1;
      mem_out.mem_rdata = 32'h1234_5678;
    end
  end

  // Output monitor: every issue and every response must match the scoreboard head.
  always @(negedge clock) begin : monitor
    iss_t ie;
    rsp_t re;
    logic noisy;
    if (mem_in.mem_valid === 1'b1) begin
      if (iss_q.size() == 0) check("unexpected_issue", 128'(mem_in), 128'(0));
      else begin
        ie = iss_q.pop_front();
        check("issue_req", 128'(mem_in), 128'(ie.req));
        check("issue_cycle", 128'(cyc), 128'(ie.cyc));
      end
    end
    noisy = 1'b0;
    for (int p = 0; p < 4; p++)
      if (req_out[p].mem_ready !== 1'b1 && req_out[p] !== '0) noisy = 1'b1;
    check("quiet_ports", 128'(noisy), 128'(0));
    for (int p = 0; p < 4; p++) begin
      if (req_out[p].mem_ready === 1'b1) begin
        if (rsp_q.size() == 0) check("unexpected_response_port", 128'(p), 128'(255));
        else begin
          re = rsp_q.pop_front();
          check("rsp_port", 128'(p), 128'(re.port));
          check("rsp_data", 128'(req_out[p]), 128'(re.rsp));
          check("rsp_cycle", 128'(cyc), 128'(re.cyc));
        end
      end
    end
  end

  function automatic mem_in_type make_req(input int p, input logic [31:0] addr);
    mem_in_type r;
    r.mem_valid = 1'b1;
    r.mem_instr = (p < 2);
    r.mem_addr  = addr;
    r.mem_wdata = addr ^ 32'h5A5A_A5A5;
    r.mem_wstrb = 4'(1 << p);
    return r;
  endfunction

  task automatic expect_txn(input int p, input logic [31:0] addr, input int issue_cyc,
                            input int lat, input logic [31:0] rd, input logic err);
    mem_out_type e;
    iss_q.push_back('{make_req(p, addr), issue_cyc});
    e.mem_ready = 1'b1;
    e.mem_error = err;
    e.mem_rdata = err ? 32'h0 : rd;
    if (err) rsp_q.push_back('{p, e, issue_cyc + int'(TMO)});
    else begin
      rdata_q.push_back(rd);
      rsp_q.push_back('{p, e, issue_cyc + lat});
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic to_cycle(input int c);
    while (cyc < c) next_cycle();
  endtask

  task automatic clear_reqs();
    for (int p = 0; p < 4; p++) req_in[p] = '0;
  endtask

  task automatic check_drained(input string name);
    check({name, "_issue_drain"}, 128'(iss_q.size()), 128'(0));
    check({name, "_rsp_drain"}, 128'(rsp_q.size()), 128'(0));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    force_ready = 1'b0;
    clear_reqs();
    rdata_q.delete();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    check("reset_mem_in", 128'(mem_in), 128'(0));
    for (int p = 0; p < 4; p++) check("reset_req_out", 128'(req_out[p]), 128'(0));
    next_cycle();
  endtask

  row_t        rows[4];
  int          t0;
  int          n;
  int          per;
  logic [31:0] addr;
  logic [31:0] rd;

  initial begin
    clear_reqs();
    rows[0] = '{"single",     4'b0100, 2, 32'h2000_0010, 32'hDEAD_BEEF};
    rows[1] = '{"contention", 4'b1111, 2, 32'h1000_0000, 32'h0000_1000};
    rows[2] = '{"pair_1_3",   4'b1010, 3, 32'h3000_0040, 32'hCAFE_0000};
    rows[3] = '{"pair_0_2",   4'b0101, 5, 32'h0000_0800, 32'h1234_0000};
    @(posedge clock);
    #1;

    // Same-cycle requests after reset are served in ascending port order.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      resp_lat = rows[r].lat;
      per = 2 + rows[r].lat;
      t0 = cyc;
      n = 0;
      for (int p = 0; p < 4; p++) begin
        if (rows[r].mask[p]) begin
          addr = rows[r].base + 32'(n) * 32'h100;
          rd   = rows[r].seed + 32'(n);
          req_in[p] = make_req(p, addr);
          expect_txn(p, addr, t0 + 2 + n * per, rows[r].lat, rd, 1'b0);
          n++;
        end
      end
      next_cycle();
      clear_reqs();
      to_cycle(t0 + 2 + n * per + 2);
      check_drained(rows[r].name);
    end

    // Fairness: a port re-requesting in its completion cycle yields to a waiting port.
    do_reset();
    resp_lat = 1;
    t0 = cyc;
    expect_txn(0, 32'h4000_0000, t0 + 2,  1, 32'hA000_0000, 1'b0);
    expect_txn(3, 32'h4300_0000, t0 + 5,  1, 32'hA300_0000, 1'b0);
    expect_txn(0, 32'h4000_1000, t0 + 8,  1, 32'hA000_1000, 1'b0);
    expect_txn(3, 32'h4300_1000, t0 + 11, 1, 32'hA300_1000, 1'b0);
    req_in[0] = make_req(0, 32'h4000_0000);
    req_in[3] = make_req(3, 32'h4300_0000);
    next_cycle();
    clear_reqs();
    to_cycle(t0 + 3);
    req_in[0] = make_req(0, 32'h4000_1000);
    next_cycle();
    clear_reqs();
    to_cycle(t0 + 6);
    req_in[3] = make_req(3, 32'h4300_1000);
    next_cycle();
    clear_reqs();
    to_cycle(t0 + 15);
    check_drained("fairness");

    // Timeout: no downstream answer, then a late ready that must be dropped.
    do_reset();
    resp_lat = 0;
    t0 = cyc;
    expect_txn(1, 32'h5000_0100, t0 + 2, 0, 32'h0, 1'b1);
    req_in[1] = make_req(1, 32'h5000_0100);
    next_cycle();
    clear_reqs();
    to_cycle(t0 + 12);
    force_ready = 1'b1;
    next_cycle();
    force_ready = 1'b0;
    to_cycle(t0 + 16);
    check_drained("timeout");

    // Duplicate: second valid while pending is ignored; one in the completion cycle is kept.
    do_reset();
    resp_lat = 3;
    t0 = cyc;
    expect_txn(1, 32'h6000_0000, t0 + 2, 3, 32'hB000_0001, 1'b0);
    expect_txn(1, 32'h6000_0C00, t0 + 7, 3, 32'hB000_0003, 1'b0);
    req_in[1] = make_req(1, 32'h6000_0000);
    next_cycle();
    req_in[1] = make_req(1, 32'h6000_0B00);
    next_cycle();
    clear_reqs();
    to_cycle(t0 + 5);
    req_in[1] = make_req(1, 32'h6000_0C00);
    next_cycle();
    clear_reqs();
    to_cycle(t0 + 13);
    check_drained("duplicate");

    // Reset during WAIT abandons the transaction; a later ready is dropped.
    do_reset();
    resp_lat = 0;
    t0 = cyc;
    iss_q.push_back('{make_req(1, 32'h7000_0000), t0 + 2});
    req_in[1] = make_req(1, 32'h7000_0000);
    next_cycle();
    clear_reqs();
    to_cycle(t0 + 4);
    reset = 1'b0;
    next_cycle();
    reset = 1'b1;
    @(negedge clock);
    check("mid_reset_mem_in", 128'(mem_in), 128'(0));
    next_cycle();
    force_ready = 1'b1;
    next_cycle();
    force_ready = 1'b0;
    resp_lat = 1;
    t0 = cyc;
    expect_txn(0, 32'h7100_0000, t0 + 2, 1, 32'hC000_0000, 1'b0);
    expect_txn(2, 32'h7200_0000, t0 + 5, 1, 32'hC000_0002, 1'b0);
    req_in[0] = make_req(0, 32'h7100_0000);
    req_in[2] = make_req(2, 32'h7200_0000);
    next_cycle();
    clear_reqs();
    to_cycle(t0 + 12);
    check_drained("reset_mid_wait");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d checks passed", passes, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
